// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: size/load-op encodings, FSM states and alignment helper shared by the memory stage
package mem_access_ctrl_pkg;
  typedef enum logic [1:0] {SZ_WORD = 2'b00, SZ_HALF = 2'b01, SZ_BYTE = 2'b10, SZ_WORD_ALT = 2'b11} size_e;
  typedef enum logic [2:0] {LD_LW = 3'b000, LD_LBU = 3'b001, LD_LB = 3'b010, LD_LHU = 3'b011, LD_LH = 3'b100} ldop_e;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return size == SZ_HALF ? lo[0] : size == SZ_BYTE ? 1'b0 : lo != 2'b00;
  endfunction
endpackage

// File: rtl/mem_access_ctrl_store_lane.sv
// store_lane_gen: byte enables and lane-replicated store data from access size and low address bits
module store_lane_gen
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  byteen,
  output logic [31:0] lane_data
);
  // half uses addr[1] only, byte uses addr[1:0], word ignores both
  always_comb begin
    byteen = size == SZ_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) : size == SZ_BYTE ? 4'b0001 << addr_lo : 4'b1111;
    lane_data = size == SZ_HALF ? {2{wdata[15:0]}} : size == SZ_BYTE ? {4{wdata[7:0]}} : wdata;
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: M-stage data-memory access controller; MISALIGN_EXC_EN enables misaligned-access exceptions
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_ldop,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_addr_lo,
  output logic [2:0]  rsp_op,
  output logic        exc_adel,
  output logic        exc_ades
);
  state_e      state;
  logic [1:0]  addr_lo;
  logic [2:0]  ldop_q;
  logic [3:0]  lane_be;
  logic [31:0] lane_data;
  logic        mis;

  store_lane_gen u_lane (
    .size      (req_size),
    .addr_lo   (req_addr[1:0]),
    .wdata     (req_wdata),
    .byteen    (lane_be),
    .lane_data (lane_data)
  );

`ifdef MISALIGN_EXC_EN
  assign mis = is_misaligned(req_size, req_addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  assign stall = !reset && ((state == S_IDLE && req_valid) || state == S_REQ || state == S_WAIT);

  // request latch, bus handshake and response capture; rsp_valid/exc_* are single-cycle pulses into DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_byteen  <= '0;
      bus_wdata   <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_addr_lo <= '0;
      rsp_op      <= '0;
      exc_adel    <= 1'b0;
      exc_ades    <= 1'b0;
      addr_lo     <= '0;
      ldop_q      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      exc_adel  <= 1'b0;
      exc_ades  <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          bus_we     <= req_we;
          bus_addr   <= {req_addr[31:2], 2'b00};
          bus_byteen <= req_we ? lane_be : 4'b0000;
          bus_wdata  <= lane_data;
          addr_lo    <= req_addr[1:0];
          ldop_q     <= req_ldop;
          if (mis) begin
            state       <= S_DONE;
            rsp_valid   <= 1'b1;
            exc_adel    <= !req_we;
            exc_ades    <= req_we;
            rsp_rdata   <= '0;
            rsp_addr_lo <= req_addr[1:0];
            rsp_op      <= req_ldop;
          end else begin
            state   <= S_REQ;
            bus_req <= 1'b1;
          end
        end
        S_REQ: if (bus_gnt) begin
          bus_req <= 1'b0;
          if (bus_we || bus_rvalid) begin
            state       <= S_DONE;
            rsp_valid   <= 1'b1;
            rsp_addr_lo <= addr_lo;
            rsp_op      <= ldop_q;
            if (!bus_we) rsp_rdata <= bus_rdata;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: if (bus_rvalid) begin
          state       <= S_DONE;
          rsp_valid   <= 1'b1;
          rsp_addr_lo <= addr_lo;
          rsp_op      <= ldop_q;
          rsp_rdata   <= bus_rdata;
        end
        S_DONE: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller between the M-stage pipeline register and a handshaked data-memory bus. It sizes and aligns store data, generates byte enables, and holds the pipeline while a transaction is outstanding. For loads, it presents the returned word, the low address bits and the load op to the downstream load-extension stage. Bus slaves may insert any number of wait states.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  M stage holds a load or store this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 word, 01 half, 10 byte (11 treated as word)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_ldop  in  3  load-extension op (lw 000, lbu 001, lb 010, lhu 011, lh 100), passed through
- stall  out  1  freeze the pipeline at and before M
- bus_req  out  1  transaction request, held until granted
- bus_we  out  1  write strobe qualifier
- bus_addr  out  32  word-aligned address, {req_addr[31:2],2'b00}
- bus_byteen  out  4  byte enables (0000 for loads)
- bus_wdata  out  32  lane-replicated store data
- bus_gnt  in  1  slave accepts the request this cycle
- bus_rvalid  in  1  load data valid this cycle
- bus_rdata  in  32  load data word
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  captured load word, feeding the load extender's data input
- rsp_addr_lo  out  2  captured req_addr[1:0]
- rsp_op  out  3  captured req_ldop
- exc_adel / exc_ades  out  1 each  misaligned load / misaligned store flags

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: when req_valid=1, latch addr, size, we, wdata and ldop, load the bus_* registers, and go to REQ. Otherwise stay in IDLE.
- REQ: bus_req=1.
  - Store with bus_gnt: go to DONE.
  - Load with bus_gnt and bus_rvalid in the same cycle: capture bus_rdata and go to DONE.
  - Load with bus_gnt only: go to WAIT.
  - Without bus_gnt: stay in REQ with all bus_* outputs stable.
- WAIT: bus_req=0. On bus_rvalid, capture bus_rdata into rsp_rdata and go to DONE.
- DONE: rsp_valid=1 and stall=0, so the pipeline advances at the end of this cycle. Go to IDLE unconditionally; a new request is accepted no earlier than the next cycle.
- stall = (IDLE & req_valid) | REQ | WAIT. stall is forced to 0 while reset=1.
- Byte enables (stores):
  - word: 1111
  - half: addr[1] ? 1100 : 0011
  - byte: 0001 << addr[1:0]
- Store data: byte = {4{wdata[7:0]}}, half = {2{wdata[15:0]}}, word = wdata.
- req_* changes during stall are ignored; the latched copy is used.
- Ignored bus inputs: bus_rvalid in IDLE, REQ-without-gnt or DONE; bus_rvalid for stores; bus_gnt outside REQ.
- rsp_rdata, rsp_addr_lo and rsp_op hold their values until the next capture.
- Reset values: state IDLE, every output 0.

## Timing
- Request sampled in cycle T with no wait states:
  - Store: bus_req high in T+1, gnt in T+1, DONE in T+2. Stall lasts 2 cycles.
  - Load: gnt in T+1, rvalid in T+2, DONE in T+3. Stall lasts 3 cycles.
- Each gnt or rvalid wait state adds one cycle.
- Reset mid-transaction: the next edge returns to IDLE and drops bus_req. A late bus_rvalid is then ignored.

## Configuration
- MISALIGN_EXC_EN defined:
  - Misalignment is word with addr[1:0]≠00, or half with addr[0]=1.
  - A misaligned request goes IDLE→DONE without asserting bus_req.
  - exc_adel (load) or exc_ades (store) is high during that DONE cycle. rsp_rdata is 0.
- MISALIGN_EXC_EN undefined:
  - Low address bits beyond the access size are ignored.
  - exc_adel and exc_ades are tied 0.
  - The ports exist in both builds.

## Structure
- Shared package: the size encodings, the load-op encodings (shared with the load extender), and the FSM state typedef.
- One sub-module, store_lane_gen: combinational size+addr[1:0]+wdata → byteen+lane data.

## Test plan
- sw 0x12345678 @0x100, gnt in T+1 → bus_byteen 1111, bus_wdata 0x12345678, stall 2 cycles, rsp_valid in T+2.
- sb 0xAB @0x103, gnt delayed 2 cycles → bus_byteen 1000, bus_wdata 0xABABABAB, bus_* stable while waiting, stall 4 cycles.
- lh op 100 @0x202, rvalid 3 cycles after gnt with 0x8001_0000 → rsp_rdata 0x80010000, rsp_addr_lo 10, rsp_op 100, rsp_valid one cycle.
- lw with gnt and rvalid in the same cycle → DONE next cycle, stall 2 cycles.
- reset asserted in WAIT, then rvalid one cycle later → IDLE, bus_req 0, rsp_valid stays 0, rsp_rdata 0.
- MISALIGN_EXC_EN, lw @0x101 → no bus_req, exc_adel pulse in T+1, stall 1 cycle; same stimulus without the macro → normal read of 0x100.
